// File: rtl/cnt_seq_ctrl_if.sv
// rtl/cnt_seq_ctrl_if.sv - command handshake bundle for the counter sequencer
interface cnt_seq_ctrl_if #(
    parameter int WIDTH = 4,
    parameter int LEN_W = 8
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [WIDTH-1:0] cmd_load_val;
    logic             cmd_down;
    logic [LEN_W-1:0] cmd_steps;

    modport master (
        output cmd_valid,
        output cmd_load_val,
        output cmd_down,
        output cmd_steps,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_load_val,
        input  cmd_down,
        input  cmd_steps,
        output cmd_ready
    );
endinterface

// File: rtl/cnt_seq_ctrl.sv
// rtl/cnt_seq_ctrl.sv - sequences a free-running counter through load/run/done
// Optional rollover abort enabled by defining CNT_SEQ_ROLLOVER_ABORT_EN.
module cnt_seq_ctrl #(
    parameter int WIDTH = 4,
    parameter int LEN_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    cnt_seq_ctrl_if.slave     cmd,
    input  logic [WIDTH-1:0]  cnt_count,
    input  logic              cnt_rollover,
    output logic              cnt_load_en,
    output logic [WIDTH-1:0]  cnt_load,
    output logic              cnt_down,
    output logic              busy,
    output logic              done,
    output logic              aborted
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [LEN_W-1:0] ONE_STEP = {{(LEN_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [WIDTH-1:0] val_q, val_d;
    logic             dir_q, dir_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic             accept;
    logic             abort_hit;

    assign cmd.cmd_ready = (state_q == S_IDLE);
    assign accept        = cmd.cmd_valid && (state_q == S_IDLE);
    assign busy          = (state_q != S_IDLE);
    assign done          = (state_q == S_DONE);
    assign cnt_down      = (state_q != S_IDLE) && dir_q;

`ifdef CNT_SEQ_ROLLOVER_ABORT_EN
    logic aborted_q, aborted_d;

    assign abort_hit = (state_q == S_RUN) && cnt_rollover;
    assign aborted   = aborted_q;

    always_comb begin
        aborted_d = aborted_q;
        if (accept) begin
            aborted_d = 1'b0;
        end else if (abort_hit) begin
            aborted_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            aborted_q <= 1'b0;
        end else begin
            aborted_q <= aborted_d;
        end
    end
`else
    logic unused_rollover;

    assign unused_rollover = cnt_rollover;
    assign abort_hit       = 1'b0;
    assign aborted         = 1'b0;
`endif

    // Outside RUN the counter is reloaded with its own value so it never drifts.
    always_comb begin
        state_d     = state_q;
        val_d       = val_q;
        dir_d       = dir_q;
        rem_d       = rem_q;
        cnt_load_en = 1'b1;
        cnt_load    = cnt_count;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    val_d   = cmd.cmd_load_val;
                    dir_d   = cmd.cmd_down;
                    rem_d   = cmd.cmd_steps;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                cnt_load = val_q;
                state_d  = (rem_q != '0) ? S_RUN : S_DONE;
            end
            S_RUN: begin
                cnt_load_en = 1'b0;
                rem_d       = rem_q - ONE_STEP;
                if (abort_hit) begin
                    cnt_load_en = 1'b1;
                    state_d     = S_DONE;
                end else if (rem_q == ONE_STEP) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            val_q   <= '0;
            dir_q   <= 1'b0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            val_q   <= val_d;
            dir_q   <= dir_d;
            rem_q   <= rem_d;
        end
    end

endmodule

// File: tb/tb_cnt_seq_ctrl.sv
// tb/tb_cnt_seq_ctrl.sv - directed scoreboard bench for cnt_seq_ctrl with a 4-bit counter
module tb_cnt_seq_ctrl;

    typedef struct {
        logic [3:0] cnt;
        logic       ab;
        int         lat;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [3:0] cnt_count;
    logic       cnt_rollover;
    logic       cnt_load_en;
    logic [3:0] cnt_load;
    logic       cnt_down;
    logic       busy;
    logic       done;
    logic       aborted;

    int   checks    = 0;
    int   failures  = 0;
    int   cyc       = 0;
    int   last_wait = 0;
    exp_t sb[$];

    cnt_seq_ctrl_if #(.WIDTH(4), .LEN_W(8)) cmd_if ();

    cnt_seq_ctrl #(.WIDTH(4), .LEN_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd          (cmd_if),
        .cnt_count    (cnt_count),
        .cnt_rollover (cnt_rollover),
        .cnt_load_en  (cnt_load_en),
        .cnt_load     (cnt_load),
        .cnt_down     (cnt_down),
        .busy         (busy),
        .done         (done),
        .aborted      (aborted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (cnt_load_en === 1'b1) cnt_count <= cnt_load;
        else if (cnt_down === 1'b1) cnt_count <= cnt_count - 4'd1;
        else cnt_count <= cnt_count + 4'd1;
    end

    assign cnt_rollover = &cnt_count;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic run_cmd(input logic [3:0] val, input logic dn, input logic [7:0] steps,
                           input logic [3:0] exp_cnt, input logic exp_ab, input int exp_lat,
                           input bit keep_valid, input string tag, output bit saw_run);
        int   waited;
        int   acc;
        int   busy_low;
        bit   seen;
        exp_t e;
        cmd_if.cmd_load_val = val;
        cmd_if.cmd_down     = dn;
        cmd_if.cmd_steps    = steps;
        cmd_if.cmd_valid    = 1'b1;
        waited = 0;
        while (cmd_if.cmd_ready !== 1'b1 && waited < 50) begin
            tick();
            waited++;
        end
        last_wait = waited;
        check({tag, "_ready_timeout"}, {31'd0, cmd_if.cmd_ready}, 32'd1);
        acc = cyc;
        sb.push_back('{exp_cnt, exp_ab, exp_lat});
        tick();
        if (!keep_valid) cmd_if.cmd_valid = 1'b0;
        check({tag, "_aborted_cleared"}, {31'd0, aborted}, 32'd0);
        seen     = 1'b0;
        busy_low = 0;
        saw_run  = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            if (done === 1'b1) begin
                seen = 1'b1;
            end else begin
                if (busy !== 1'b1) busy_low++;
                if (busy === 1'b1 && cnt_load_en === 1'b0) saw_run = 1'b1;
                tick();
            end
        end
        check({tag, "_done_timeout"}, {31'd0, seen}, 32'd1);
        if (seen) begin
            e = sb.pop_front();
            check({tag, "_count"},    {28'd0, cnt_count}, {28'd0, e.cnt});
            check({tag, "_aborted"},  {31'd0, aborted},   {31'd0, e.ab});
            check({tag, "_latency"},  cyc - acc,          e.lat);
            check({tag, "_busy_gap"}, busy_low,           0);
            check({tag, "_ready_in_done"}, {31'd0, cmd_if.cmd_ready}, 32'd0);
        end
    endtask

    initial begin
        bit sr;
        bit done_seen;
        rst = 1'b1;
        cmd_if.cmd_valid    = 1'b0;
        cmd_if.cmd_load_val = 4'd0;
        cmd_if.cmd_down     = 1'b0;
        cmd_if.cmd_steps    = 8'd0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("rst_ready",   {31'd0, cmd_if.cmd_ready}, 32'd1);
        check("rst_busy",    {31'd0, busy},        32'd0);
        check("rst_done",    {31'd0, done},        32'd0);
        check("rst_aborted", {31'd0, aborted},     32'd0);
        check("rst_load_en", {31'd0, cnt_load_en}, 32'd1);
        check("rst_cnt_down", {31'd0, cnt_down},   32'd0);

        // Count up 3 by 5
        run_cmd(4'd3, 1'b0, 8'd5, 4'd8, 1'b0, 7, 1'b0, "up", sr);
        check("up_saw_run", {31'd0, sr}, 32'd1);
        tick();
        check("up_done_pulse", {31'd0, done}, 32'd0);
        check("up_idle_ready", {31'd0, cmd_if.cmd_ready}, 32'd1);
        tick();
        tick();
        tick();
        check("up_hold", {28'd0, cnt_count}, 32'd8);

        // Zero steps skips RUN
        run_cmd(4'd9, 1'b0, 8'd0, 4'd9, 1'b0, 2, 1'b0, "zero", sr);
        check("zero_no_run", {31'd0, sr}, 32'd0);
        tick();

        // Down through zero
`ifdef CNT_SEQ_ROLLOVER_ABORT_EN
        run_cmd(4'd1, 1'b1, 8'd3, 4'd15, 1'b1, 5, 1'b0, "down", sr);
`else
        run_cmd(4'd1, 1'b1, 8'd3, 4'd14, 1'b0, 5, 1'b0, "down", sr);
`endif
        tick();
        check("down_idle_dir", {31'd0, cnt_down}, 32'd0);

        // Back-to-back with cmd_valid held high
        run_cmd(4'd2, 1'b0, 8'd2, 4'd4, 1'b0, 4, 1'b1, "b2b_a", sr);
`ifdef CNT_SEQ_ROLLOVER_ABORT_EN
        run_cmd(4'd5, 1'b0, 8'd255, 4'd15, 1'b1, 13, 1'b0, "b2b_b", sr);
`else
        run_cmd(4'd5, 1'b0, 8'd255, 4'd4, 1'b0, 257, 1'b0, "b2b_b", sr);
`endif
        check("b2b_idle_cycles", last_wait, 1);
        tick();

        // Reset in the 4th RUN cycle
        cmd_if.cmd_load_val = 4'd0;
        cmd_if.cmd_down     = 1'b0;
        cmd_if.cmd_steps    = 8'd10;
        cmd_if.cmd_valid    = 1'b1;
        check("mid_ready", {31'd0, cmd_if.cmd_ready}, 32'd1);
        done_seen = 1'b0;
        tick();
        cmd_if.cmd_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            done_seen |= (done === 1'b1);
        end
        check("mid_in_run", {31'd0, cnt_load_en}, 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        done_seen |= (done === 1'b1);
        check("mid_busy",    {31'd0, busy},             32'd0);
        check("mid_ready2",  {31'd0, cmd_if.cmd_ready}, 32'd1);
        check("mid_load_en", {31'd0, cnt_load_en},      32'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            done_seen |= (done === 1'b1);
        end
        check("mid_no_done", {31'd0, done_seen}, 32'd0);
        check("mid_hold",    {28'd0, cnt_count}, 32'd4);
        check("sb_empty",    sb.size(),          0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cnt_seq_ctrl.md
CNT_SEQ_CTRL -- requirements
Module: cnt_seq_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 4, meaning the counter data width.
REQ-002 SHALL have parameter LEN_W, default 8, meaning the step-count width.
REQ-003 SHALL have one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  rising-edge clock for all state.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 cmd_valid  in  1  command offered.
REQ-007 cmd_ready  out  1  high only in IDLE; a command is accepted on any edge where cmd_valid & cmd_ready.
REQ-008 cmd_load_val  in  WIDTH  start value for the counter.
REQ-009 cmd_down  in  1  direction: 1 = down, 0 = up.
REQ-010 cmd_steps  in  LEN_W  number of count steps to run.
REQ-011 cnt_count  in  WIDTH  current counter value.
REQ-012 cnt_rollover  in  1  counter all-ones flag.
REQ-013 cnt_load_en  out  1  counter load enable.
REQ-014 cnt_load  out  WIDTH  counter load value.
REQ-015 cnt_down  out  1  counter direction.
REQ-016 busy  out  1  high in LOAD, RUN and DONE.
REQ-017 done  out  1  one-cycle completion pulse.
REQ-018 aborted  out  1  status of the last command; valid while done is high and held until the next acceptance.

Function
REQ-019 SHALL implement the FSM IDLE -> LOAD -> RUN -> DONE -> IDLE.
REQ-020 Accepting a command SHALL register cmd_load_val, cmd_down and cmd_steps, clear aborted, and move IDLE -> LOAD.
REQ-021 Hold rule: in IDLE and DONE, SHALL drive cnt_load_en=1 and cnt_load=cnt_count so that the free-running counter stays frozen.
REQ-022 LOAD: SHALL drive cnt_load_en=1 and cnt_load=<latched val>; next state is RUN if steps!=0, else DONE.
REQ-023 RUN: SHALL drive cnt_load_en=0 and cnt_down=<latched dir>, and decrement a remaining-steps register each cycle.
REQ-024 RUN SHALL last exactly steps cycles; exit to DONE on the edge where remaining==1.
REQ-025 Final count SHALL equal (val + steps) mod 2^WIDTH (up) or (val - steps) mod 2^WIDTH (down); counter wrap is permitted.
REQ-026 done SHALL be high exactly in the DONE cycle, which is steps+2 cycles after the acceptance edge.
REQ-027 cnt_down SHALL hold the latched direction in all states except IDLE, where it is 0.
REQ-028 cmd_valid outside IDLE SHALL be ignored (cmd_ready=0); back-to-back acceptance SHALL be possible in the first IDLE cycle after DONE.
REQ-029 The remaining-steps register SHALL be LEN_W bits wide; cmd_steps=2^LEN_W-1 SHALL be supported without overflow.

Reset
REQ-030 rst SHALL force state=IDLE, busy=0, done=0, aborted=0 and clear latched command registers, with priority over all other events including mid-RUN.
REQ-031 In the first cycle after rst deasserts: cmd_ready=1, cnt_load_en=1 (hold), cnt_down=0.

Configuration
REQ-032 Macro CNT_SEQ_ROLLOVER_ABORT_EN.
REQ-033 When the macro is defined, a RUN cycle with cnt_rollover=1 SHALL:
  - drive hold (cnt_load_en=1, cnt_load=cnt_count);
  - go to DONE and set aborted=1.
  This applies in either direction, including the first RUN cycle.
REQ-034 When the macro is undefined, cnt_rollover SHALL be ignored and aborted SHALL be tied to 0.

Verification (WIDTH=4, LEN_W=8; the bench uses a counter with these ports)
REQ-035 Reset: assert rst 2 cycles -> cmd_ready=1, busy=0, done=0, aborted=0, cnt_load_en=1.
REQ-036 Count up: val=3, down=0, steps=5 -> done is high 7 cycles after acceptance, count=8, aborted=0; count stays 8 thereafter.
REQ-037 Zero steps: val=9, steps=0 -> done 2 cycles after acceptance, count=9, and RUN is never entered.
REQ-038 Down wrap: val=1, down=1, steps=3:
  - without macro -> count=14, aborted=0;
  - with macro -> RUN stops at count=15, aborted=1, done is high 5 cycles after acceptance.
REQ-039 Busy/back-to-back: cmd_valid held high through the command -> second command accepted only in the IDLE cycle after DONE, and busy is never low between the two commands except that one cycle.
REQ-040 Reset mid-RUN: val=0, steps=10, rst on the 4th RUN cycle -> next cycle IDLE, done never pulses, cnt_load_en=1.
